// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops len bytes from the FIFO and presents them on a valid/ready stream
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  abort,
   input  logic                  fifo_empty,
   output logic                  fifo_read,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  sent
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  issue_left;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  pop;
   logic                  capture;
   logic [2:0]            pending;

   // Issue decision: bytes already owed to the buffer (held + in flight - leaving) must leave room for one more
   always_comb begin
      pop       = m_valid && m_ready;
      capture   = inflight && !abort;
      pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      fifo_read = (state == RUN) && (issue_left != '0) && !fifo_empty &&
                  (pending <= 3'd1) && !abort && !rst;
   end

   assign m_data = head_q;
   assign m_last = m_valid && (sent == len_r - 1'b1);
   assign busy   = (state == RUN) || (state == DRAIN);
   assign done   = (state == DONE);

   // Two-entry output buffer: capture at the tail, pop from the head; abort drops everything
   always_ff @(posedge clk) begin
      if (rst) begin
         occ     <= 2'd0;
         m_valid <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (abort) begin
         occ     <= 2'd0;
         m_valid <= 1'b0;
      end else begin
         occ     <= pending[1:0];
         m_valid <= (pending != 3'd0);
         case (occ)
            2'd0: begin
               if (capture) head_q <= fifo_data;
            end
            2'd1: begin
               if (capture && pop) head_q <= fifo_data;
               else if (capture)   tail_q <= fifo_data;
            end
            default: begin
               if (pop) begin
                  head_q <= tail_q;
                  if (capture) tail_q <= fifo_data;
               end
            end
         endcase
      end
   end

   // Transfer sequencing, read/pop counters and the in-flight read flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         issue_left <= '0;
         len_r      <= '0;
         sent       <= '0;
         inflight   <= 1'b0;
      end else begin
         inflight <= fifo_read;
         if (pop && !abort) sent <= sent + 1'b1;
         if (fifo_read)     issue_left <= issue_left - 1'b1;
         if (abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     len_r      <= len;
                     issue_left <= len;
                     sent       <= '0;
                     // a zero-length request passes through DRAIN so done lands two cycles after start
                     state      <= (len == '0) ? DRAIN : RUN;
                  end
               end
               RUN: begin
                  if (fifo_read && issue_left == LEN_WIDTH'(1)) state <= DRAIN;
               end
               DRAIN: begin
                  if (pending == 3'd0) state <= DONE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   // A capture into a full buffer that is not draining would lose a byte
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(capture && occ == 2'd2 && !pop));
`endif

endmodule
